decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and immediate (32 or 64).
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port flush, input, 1, discards the held entry.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-007 SHALL have ports Instruction (input, 32) and PC (input, XLEN), the upstream payload.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-009 SHALL have 1-bit registered outputs RegWrite, ALUSrc, MemWrite, Branch, Jump and Illegal.
REQ-010 SHALL have registered outputs ResultSrc (2), ImmSrc (3) and ALUControl (4).
REQ-011 SHALL have registered outputs Imm (XLEN), Rs1, Rs2 and Rd (5 each), and PC_out (XLEN).
REQ-012 SHALL have port IllegalCount, output, CNT_W, the saturating count of accepted illegal instructions.

Function
REQ-013 SHALL hold one entry; in_ready = !out_valid | out_ready, combinational, with no other dependency.
REQ-014 SHALL accept an instruction when in_valid & in_ready; decoded fields SHALL appear on the outputs next cycle with out_valid=1 (latency 1).
REQ-015 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-016 SHALL clear out_valid when the entry is consumed (out_ready=1) and no new accept happens in that cycle.
REQ-017 SHALL give flush priority over accept: a flush cycle sets out_valid=0 next cycle and drops any instruction accepted in that cycle.
REQ-018 SHALL update IllegalCount only for accepted, non-flushed instructions.
REQ-019 SHALL decode these opcodes: load 0000011, store 0100011, R-type 0110011, I-ALU 0010011, branch 1100011, JAL 1101111, LUI 0110111.
REQ-020 SHALL set RegWrite for load, R-type, I-ALU, JAL and LUI.
REQ-021 SHALL set ALUSrc for load, store, I-ALU and LUI.
REQ-022 SHALL set MemWrite for store only, Branch for branch only, and Jump for JAL only.
REQ-023 SHALL set ResultSrc to 00 (ALU), 01 (memory) for load, or 10 (PC+4) for JAL.
REQ-024 SHALL set ImmSrc to 000 for I-type/load, 001 for S, 010 for B, 011 for J, or 100 for U.
REQ-025 SHALL build Imm per ImmSrc and sign-extend it to XLEN; B and J immediates have bit 0 = 0; U = {Instr[31:12], 12'b0} sign-extended.
REQ-026 SHALL encode ALUControl as add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000.
REQ-027 SHALL use add for load, store, JAL and LUI, and sub for branch.
REQ-028 SHALL decode R-type by funct3: 000 gives sub if funct7[5] else add; 001 sll; 010 slt; 100 xor; 101 sra if funct7[5] else srl; 110 or; 111 and.
REQ-029 SHALL decode I-ALU the same way, except funct3 000 is always add.
REQ-030 SHALL treat any other opcode as illegal: Illegal=1; RegWrite, MemWrite, Branch and Jump = 0; ALUControl=0000.
REQ-031 SHALL increment IllegalCount once per illegal accept and saturate at 2^CNT_W-1 without wrapping.
REQ-032 SHALL pass Rs1=Instr[19:15], Rs2=Instr[24:20], Rd=Instr[11:7] and PC_out=PC unchanged.

Reset
REQ-033 SHALL, on a clock edge with rst_n=0, clear out_valid, all control outputs, Imm, Rs1, Rs2, Rd, PC_out and IllegalCount to 0.
REQ-034 SHALL make in_ready=1 in the cycle after reset; reset mid-transfer discards the held entry and the accept in that cycle.

Verification
REQ-035 Bench SHALL check: accept 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, ALUControl=0000, RegWrite=1, Rd=3, Rs1=1, Rs2=2.
REQ-036 Bench SHALL check: accept 0x402081B3 -> ALUControl=0001; accept 0x00812283 (lw x5,8(x2)) -> ResultSrc=01, ALUSrc=1, Imm=8.
REQ-037 Bench SHALL check: accept 0xFE512E23 (sw x5,-4(x2)) -> MemWrite=1, RegWrite=0, ImmSrc=001, Imm=0xFFFFFFFC at XLEN=32.
REQ-038 Bench SHALL check: hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; raise out_ready -> next instruction accepted the same cycle.
REQ-039 Bench SHALL check: flush together with in_valid=1 -> out_valid=0 next cycle, IllegalCount unchanged.
REQ-040 Bench SHALL check: with CNT_W=2, send 5 accepted 0x0000007F -> Illegal=1 each time, IllegalCount stops at 3.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry registered RV32 subset decoder with valid/ready handshake
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      Instruction,
   input  logic [XLEN-1:0]  PC,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             MemWrite,
   output logic             Branch,
   output logic             Jump,
   output logic             Illegal,
   output logic [1:0]       ResultSrc,
   output logic [2:0]       ImmSrc,
   output logic [3:0]       ALUControl,
   output logic [XLEN-1:0]  Imm,
   output logic [4:0]       Rs1,
   output logic [4:0]       Rs2,
   output logic [4:0]       Rd,
   output logic [XLEN-1:0]  PC_out,
   output logic [CNT_W-1:0] IllegalCount
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic        reg_write_d, alu_src_d, mem_write_d, branch_d, jump_d, illegal_d;
   logic [1:0]  result_src_d;
   logic [2:0]  imm_src_d;
   logic [3:0]  alu_ctrl_d;
   logic [31:0] imm32;
   logic        accept;

   assign in_ready = !out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Shared R/I ALU decode; allow_sub is 0 for I-ALU so funct3=000 is always add.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                             input logic allow_sub);
      logic [3:0] r;
      r = 4'b0000;
      case (f3)
         3'b000:  r = (allow_sub && f7b5) ? 4'b0001 : 4'b0000;
         3'b001:  r = 4'b0110;
         3'b010:  r = 4'b0101;
         3'b100:  r = 4'b0100;
         3'b101:  r = f7b5 ? 4'b1000 : 4'b0111;
         3'b110:  r = 4'b0011;
         3'b111:  r = 4'b0010;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   always_comb begin
      reg_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      mem_write_d  = 1'b0;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      illegal_d    = 1'b0;
      result_src_d = 2'b00;
      imm_src_d    = 3'b000;
      alu_ctrl_d   = 4'b0000;
      case (Instruction[6:0])
         OP_LOAD: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 1'b1;
            result_src_d = 2'b01;
         end
         OP_STORE: begin
            alu_src_d   = 1'b1;
            mem_write_d = 1'b1;
            imm_src_d   = 3'b001;
         end
         OP_R: begin
            reg_write_d = 1'b1;
            alu_ctrl_d  = alu_decode(Instruction[14:12], Instruction[30], 1'b1);
         end
         OP_I: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_ctrl_d  = alu_decode(Instruction[14:12], Instruction[30], 1'b0);
         end
         OP_BR: begin
            branch_d   = 1'b1;
            imm_src_d  = 3'b010;
            alu_ctrl_d = 4'b0001;
         end
         OP_JAL: begin
            reg_write_d  = 1'b1;
            jump_d       = 1'b1;
            result_src_d = 2'b10;
            imm_src_d    = 3'b011;
         end
         OP_LUI: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            imm_src_d   = 3'b100;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   // Immediates are assembled at 32 bits and then sign-extended to XLEN.
   always_comb begin
      imm32 = 32'd0;
      case (imm_src_d)
         3'b001:  imm32 = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
         3'b010:  imm32 = {{20{Instruction[31]}}, Instruction[7], Instruction[30:25],
                           Instruction[11:8], 1'b0};
         3'b011:  imm32 = {{12{Instruction[31]}}, Instruction[19:12], Instruction[20],
                           Instruction[30:21], 1'b0};
         3'b100:  imm32 = {Instruction[31:12], 12'd0};
         default: imm32 = {{20{Instruction[31]}}, Instruction[31:20]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         RegWrite     <= 1'b0;
         ALUSrc       <= 1'b0;
         MemWrite     <= 1'b0;
         Branch       <= 1'b0;
         Jump         <= 1'b0;
         Illegal      <= 1'b0;
         ResultSrc    <= 2'b00;
         ImmSrc       <= 3'b000;
         ALUControl   <= 4'b0000;
         Imm          <= '0;
         Rs1          <= 5'd0;
         Rs2          <= 5'd0;
         Rd           <= 5'd0;
         PC_out       <= '0;
         IllegalCount <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         RegWrite   <= reg_write_d;
         ALUSrc     <= alu_src_d;
         MemWrite   <= mem_write_d;
         Branch     <= branch_d;
         Jump       <= jump_d;
         Illegal    <= illegal_d;
         ResultSrc  <= result_src_d;
         ImmSrc     <= imm_src_d;
         ALUControl <= alu_ctrl_d;
         Imm        <= XLEN'($signed(imm32));
         Rs1        <= Instruction[19:15];
         Rs2        <= Instruction[24:20];
         Rd         <= Instruction[11:7];
         PC_out     <= PC;
         if (illegal_d && (IllegalCount != {CNT_W{1'b1}}))
            IllegalCount <= IllegalCount + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] Instruction, PC;
   logic        RegWrite, ALUSrc, MemWrite, Branch, Jump, Illegal;
   logic [1:0]  ResultSrc;
   logic [2:0]  ImmSrc;
   logic [3:0]  ALUControl;
   logic [31:0] Imm, PC_out;
   logic [4:0]  Rs1, Rs2, Rd;
   logic [1:0]  IllegalCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .Instruction(Instruction), .PC(PC),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
      .Branch(Branch), .Jump(Jump), .Illegal(Illegal),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .PC_out(PC_out),
      .IllegalCount(IllegalCount)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are then stable for checking.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      Instruction = 32'd0; PC = 32'd0;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_regwrite", RegWrite, 0);
      check("rst_imm", Imm, 0);
      check("rst_rd", Rd, 0);
      check("rst_illcnt", IllegalCount, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      in_valid = 1'b1; Instruction = 32'h002081B3; PC = 32'h100;
      tick();
      check("add_valid", out_valid, 1);
      check("add_aluctl", ALUControl, 4'b0000);
      check("add_regwrite", RegWrite, 1);
      check("add_rd", Rd, 3);
      check("add_rs1", Rs1, 1);
      check("add_rs2", Rs2, 2);
      check("add_pc", PC_out, 32'h100);

      Instruction = 32'h402081B3; PC = 32'h104;
      tick();
      check("sub_aluctl", ALUControl, 4'b0001);

      Instruction = 32'h00812283; PC = 32'h108;
      tick();
      check("lw_resultsrc", ResultSrc, 2'b01);
      check("lw_alusrc", ALUSrc, 1);
      check("lw_imm", Imm, 32'd8);
      check("lw_rd", Rd, 5);

      Instruction = 32'hFE512E23; PC = 32'h10C;
      tick();
      check("sw_memwrite", MemWrite, 1);
      check("sw_regwrite", RegWrite, 0);
      check("sw_immsrc", ImmSrc, 3'b001);
      check("sw_imm", Imm, 32'hFFFFFFFC);

      out_ready = 1'b0; Instruction = 32'h002081B3; PC = 32'h110;
      #1;
      check("stall_in_ready_comb", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", out_valid, 1);
         check("stall_memwrite", MemWrite, 1);
         check("stall_imm", Imm, 32'hFFFFFFFC);
         check("stall_pc", PC_out, 32'h10C);
         check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      tick();
      check("release_valid", out_valid, 1);
      check("release_memwrite", MemWrite, 0);
      check("release_rd", Rd, 3);
      check("release_pc", PC_out, 32'h110);

      Instruction = 32'h00208463;
      tick();
      check("beq_branch", Branch, 1);
      check("beq_immsrc", ImmSrc, 3'b010);
      check("beq_imm", Imm, 32'd8);
      check("beq_aluctl", ALUControl, 4'b0001);
      check("beq_regwrite", RegWrite, 0);

      Instruction = 32'h0080006F;
      tick();
      check("jal_jump", Jump, 1);
      check("jal_resultsrc", ResultSrc, 2'b10);
      check("jal_immsrc", ImmSrc, 3'b011);
      check("jal_imm", Imm, 32'd8);
      check("jal_regwrite", RegWrite, 1);

      Instruction = 32'h123452B7;
      tick();
      check("lui_imm", Imm, 32'h12345000);
      check("lui_immsrc", ImmSrc, 3'b100);
      check("lui_alusrc", ALUSrc, 1);

      Instruction = 32'h4030D093;
      tick();
      check("srai_aluctl", ALUControl, 4'b1000);
      check("srai_imm", Imm, 32'h403);

      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);

      in_valid = 1'b1; flush = 1'b1; Instruction = 32'h0000007F;
      tick();
      check("flush_valid", out_valid, 0);
      check("flush_illcnt", IllegalCount, 0);
      flush = 1'b0;

      for (int i = 0; i < 5; i++) begin
         tick();
         check("ill_flag", Illegal, 1);
         check("ill_regwrite", RegWrite, 0);
         check("ill_aluctl", ALUControl, 4'b0000);
         check("ill_count", IllegalCount, (i < 3) ? i + 1 : 3);
      end

      rst_n = 1'b0; Instruction = 32'h002081B3;
      tick();
      check("midrst_valid", out_valid, 0);
      check("midrst_illcnt", IllegalCount, 0);
      check("midrst_rd", Rd, 0);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      check("midrst_in_ready", in_ready, 1);
      check("midrst_still_empty", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
